// File: rtl/ex_hazard_ctrl_if.sv
// EX-stage hazard controller bundle.
// ID-side inputs, EX feedback and control outputs.
interface ex_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int ADDR_W = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_branch;
  logic              ex_zero;
  logic [ADDR_W-1:0] ex_branch_addr;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall;
  logic              flush;
  logic              pc_redirect;
  logic [ADDR_W-1:0] pc_redirect_addr;
  logic              ex_valid;

  modport master (
    output id_valid, id_rs, id_rt, id_rd,
    output id_reg_write, id_mem_read, id_branch,
    output ex_zero, ex_branch_addr,
    input  fwd_a, fwd_b, stall, flush,
    input  pc_redirect, pc_redirect_addr, ex_valid
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd,
    input  id_reg_write, id_mem_read, id_branch,
    input  ex_zero, ex_branch_addr,
    output fwd_a, fwd_b, stall, flush,
    output pc_redirect, pc_redirect_addr, ex_valid
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding selects,
// load-use stall and taken-branch redirect/flush.
module ex_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input logic            clk,
  input logic            reset,
  ex_hazard_ctrl_if.slave hz
);
  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;

  logic              ex_v_q, ex_rw_q, ex_mr_q, ex_br_q;
  logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
  logic              mem_v_q, mem_rw_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              wb_v_q, wb_rw_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic take, load_use, stall_c, flush_c;

  // EX/MEM wins over MEM/WB; r0 is never a source
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src
  );
    logic [1:0] sel;
    logic       hit_mem, hit_wb;
    hit_mem = mem_v_q & mem_rw_q
            & (mem_rd_q != '0) & (mem_rd_q == src);
    hit_wb  = wb_v_q & wb_rw_q
            & (wb_rd_q != '0) & (wb_rd_q == src);
    sel = 2'b00;
    priority case (1'b1)
      !ex_v_q: sel = 2'b00;
      hit_mem: sel = 2'b10;
      hit_wb:  sel = 2'b01;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  // hazard detection from registered EX state and live ID fields
  always_comb begin
    take     = (state_q == RUN) & ex_v_q
             & ex_br_q & hz.ex_zero;
    load_use = ex_v_q & ex_mr_q & (ex_rd_q != '0)
             & hz.id_valid
             & ((ex_rd_q == hz.id_rs)
             | (ex_rd_q == hz.id_rt));
    stall_c  = (state_q == RUN) & ~take & load_use;
    flush_c  = take | (state_q == FLUSH);
  end

  // flush FSM next state; FLUSH holds until count hits 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (take && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // outputs, all forced low while reset is held
  always_comb begin
    hz.fwd_a            = 2'b00;
    hz.fwd_b            = 2'b00;
    hz.stall            = 1'b0;
    hz.flush            = 1'b0;
    hz.pc_redirect      = 1'b0;
    hz.pc_redirect_addr = '0;
    hz.ex_valid         = 1'b0;
    if (!reset) begin
      hz.fwd_a            = fwd_sel(ex_rs_q);
      hz.fwd_b            = fwd_sel(ex_rt_q);
      hz.stall            = stall_c;
      hz.flush            = flush_c;
      hz.pc_redirect      = take;
      hz.pc_redirect_addr = take ? hz.ex_branch_addr
                                 : addr_q;
      hz.ex_valid         = ex_v_q;
    end
  end

  // shadow pipe, FSM and last redirect target
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      ex_v_q   <= 1'b0;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      ex_br_q  <= 1'b0;
      ex_rs_q  <= '0;
      ex_rt_q  <= '0;
      ex_rd_q  <= '0;
      mem_v_q  <= 1'b0;
      mem_rw_q <= 1'b0;
      mem_rd_q <= '0;
      wb_v_q   <= 1'b0;
      wb_rw_q  <= 1'b0;
      wb_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if (take) addr_q <= hz.ex_branch_addr;
      ex_v_q   <= hz.id_valid & ~stall_c & ~flush_c;
      ex_rw_q  <= hz.id_reg_write;
      ex_mr_q  <= hz.id_mem_read;
      ex_br_q  <= hz.id_branch;
      ex_rs_q  <= hz.id_rs;
      ex_rt_q  <= hz.id_rt;
      ex_rd_q  <= hz.id_rd;
      mem_v_q  <= ex_v_q;
      mem_rw_q <= ex_rw_q;
      mem_rd_q <= ex_rd_q;
      wb_v_q   <= mem_v_q;
      wb_rw_q  <= mem_rw_q;
      wb_rd_q  <= mem_rd_q;
    end
  end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed table, corner
// sequences and random traffic against a model.
module tb_ex_hazard_ctrl;
  localparam int FC0 = 1;
  localparam int FC1 = 3;

  typedef struct packed {
    logic        rst, idv;
    logic [4:0]  rs, rt, rd;
    logic        rw, mr, br, zero;
    logic [31:0] ba;
  } in_t;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic        st, fl, rdr, ev;
    logic [31:0] ad;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  typedef struct {
    bit       v, rw, mr, br;
    bit [4:0] rs, rt, rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.REG_AW(5), .ADDR_W(32)) bus0();
  ex_hazard_ctrl_if #(.REG_AW(5), .ADDR_W(32)) bus1();

  ex_hazard_ctrl #(
    .REG_AW(5), .ADDR_W(32), .FLUSH_CYCLES(FC0)
  ) dut0 (.clk(clk), .reset(rst), .hz(bus0));

  ex_hazard_ctrl #(
    .REG_AW(5), .ADDR_W(32), .FLUSH_CYCLES(FC1)
  ) dut1 (.clk(clk), .reset(rst), .hz(bus1));

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  ins_t pipe[2][3];
  int   fl_left[2];
  logic [31:0] last_ad[2];

  function automatic in_t iv(
    bit rs_, bit idv, bit [4:0] rs, bit [4:0] rt,
    bit [4:0] rd, bit rw, bit mr, bit br, bit z,
    bit [31:0] ba);
    in_t x;
    x.rst = rs_; x.idv = idv;
    x.rs = rs; x.rt = rt; x.rd = rd;
    x.rw = rw; x.mr = mr; x.br = br;
    x.zero = z; x.ba = ba;
    return x;
  endfunction

  function automatic out_t ev(
    bit [1:0] fa, bit [1:0] fb, bit st, bit fl,
    bit rdr, bit e, bit [31:0] ad);
    out_t o;
    o.fa = fa; o.fb = fb; o.st = st; o.fl = fl;
    o.rdr = rdr; o.ev = e; o.ad = ad;
    return o;
  endfunction

  function automatic bit [1:0] src(int d, bit [4:0] r);
    for (int k = 1; k <= 2; k++) begin
      if (pipe[d][k].v && pipe[d][k].rw &&
          r != 5'd0 && pipe[d][k].rd == r)
        return (k == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic out_t mdl_out(int d, in_t x);
    out_t o;
    ins_t e;
    bit   take, busy;
    o = '0;
    if (x.rst) return o;
    e    = pipe[d][0];
    busy = fl_left[d] > 0;
    take = !busy && e.v && e.br && x.zero;
    if (e.v) begin
      o.fa = src(d, e.rs);
      o.fb = src(d, e.rt);
    end
    o.st = !busy && !take && e.v && e.mr &&
           e.rd != 5'd0 && x.idv &&
           (e.rd == x.rs || e.rd == x.rt);
    o.fl  = take || busy;
    o.rdr = take;
    o.ev  = e.v;
    o.ad  = take ? x.ba : last_ad[d];
    return o;
  endfunction

  task automatic mdl_step(int d, in_t x);
    out_t o;
    ins_t n;
    o = mdl_out(d, x);
    if (x.rst) begin
      for (int k = 0; k < 3; k++) pipe[d][k] = '{default: 0};
      fl_left[d] = 0;
      last_ad[d] = '0;
    end else begin
      pipe[d][2] = pipe[d][1];
      pipe[d][1] = pipe[d][0];
      n = '{default: 0};
      if (x.idv && !o.st && !o.fl) begin
        n.v = 1; n.rw = x.rw; n.mr = x.mr; n.br = x.br;
        n.rs = x.rs; n.rt = x.rt; n.rd = x.rd;
      end
      pipe[d][0] = n;
      if (o.rdr) begin
        last_ad[d] = x.ba;
        fl_left[d] = ((d == 0) ? FC0 : FC1) - 1;
      end else if (fl_left[d] > 0) begin
        fl_left[d]--;
      end
    end
  endtask

  function automatic out_t act(int d);
    if (d == 0)
      return out_t'({bus0.fwd_a, bus0.fwd_b,
        bus0.stall, bus0.flush, bus0.pc_redirect,
        bus0.ex_valid, bus0.pc_redirect_addr});
    return out_t'({bus1.fwd_a, bus1.fwd_b,
      bus1.stall, bus1.flush, bus1.pc_redirect,
      bus1.ex_valid, bus1.pc_redirect_addr});
  endfunction

  task automatic drive(in_t x);
    rst = x.rst;
    bus0.id_valid = x.idv;     bus1.id_valid = x.idv;
    bus0.id_rs = x.rs;         bus1.id_rs = x.rs;
    bus0.id_rt = x.rt;         bus1.id_rt = x.rt;
    bus0.id_rd = x.rd;         bus1.id_rd = x.rd;
    bus0.id_reg_write = x.rw;  bus1.id_reg_write = x.rw;
    bus0.id_mem_read = x.mr;   bus1.id_mem_read = x.mr;
    bus0.id_branch = x.br;     bus1.id_branch = x.br;
    bus0.ex_zero = x.zero;     bus1.ex_zero = x.zero;
    bus0.ex_branch_addr = x.ba;
    bus1.ex_branch_addr = x.ba;
  endtask

  // mode 1: dut0 vs e; mode 2: dut1 vs e; else model
  task automatic apply(string nm, in_t x, int mode,
                       out_t e);
    out_t want, got;
    @(negedge clk);
    drive(x);
    #2;
    for (int d = 0; d < 2; d++) begin
      want = ((mode == 1 && d == 0) ||
              (mode == 2 && d == 1)) ? e : mdl_out(d, x);
      got  = act(d);
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s dut%0d: got %h want %h",
                 nm, d, got, want);
      end
    end
    for (int d = 0; d < 2; d++) mdl_step(d, x);
  endtask

  task automatic row(in_t i, out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  initial begin
    in_t  x;
    out_t z;
    z = '0;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) pipe[d][k] = '{default: 0};
      fl_left[d] = 0;
      last_ad[d] = '0;
    end
    drive(iv(1,0,0,0,0,0,0,0,0,0));

    // reset, forwarding, load-use, branch, r0
    row(iv(1,1,1,2,3,1,0,0,0,0),     ev(0,0,0,0,0,0,0));
    row(iv(0,1,1,2,3,1,0,0,0,0),     ev(0,0,0,0,0,0,0));
    row(iv(0,1,3,4,5,1,0,0,0,0),     ev(0,0,0,0,0,1,0));
    row(iv(0,1,4,3,6,1,0,0,0,0),     ev(2,0,0,0,0,1,0));
    row(iv(0,0,0,0,0,0,0,0,0,0),     ev(0,1,0,0,0,1,0));
    row(iv(0,1,0,0,3,1,0,0,0,0),     ev(0,0,0,0,0,0,0));
    row(iv(0,1,7,8,3,1,0,0,0,0),     ev(0,0,0,0,0,1,0));
    row(iv(0,1,3,3,9,1,0,0,0,0),     ev(0,0,0,0,0,1,0));
    row(iv(0,0,0,0,0,0,0,0,0,0),     ev(2,2,0,0,0,1,0));
    row(iv(0,1,1,0,2,1,1,0,0,0),     ev(0,0,0,0,0,0,0));
    row(iv(0,1,2,2,4,1,0,0,0,0),     ev(0,0,1,0,0,1,0));
    row(iv(0,1,2,2,4,1,0,0,0,0),     ev(0,0,0,0,0,0,0));
    row(iv(0,0,0,0,0,0,0,0,0,0),     ev(1,1,0,0,0,1,0));
    row(iv(0,1,0,0,0,0,0,1,0,0),     ev(0,0,0,0,0,0,0));
    row(iv(0,1,4,4,7,1,0,0,1,'h40),  ev(0,0,0,1,1,1,'h40));
    row(iv(0,0,0,0,0,0,0,0,1,'h80),  ev(0,0,0,0,0,0,'h40));
    row(iv(0,1,0,0,0,0,0,1,0,0),     ev(0,0,0,0,0,0,'h40));
    row(iv(0,0,0,0,0,0,0,0,0,'h99),  ev(0,0,0,0,0,1,'h40));
    row(iv(0,1,1,1,0,1,1,0,0,0),     ev(0,0,0,0,0,0,'h40));
    row(iv(0,1,0,0,8,1,0,0,0,0),     ev(0,0,0,0,0,1,'h40));
    row(iv(0,0,0,0,0,0,0,0,0,0),     ev(0,0,0,0,0,1,'h40));
    row(iv(1,1,1,2,3,1,1,1,1,'hff),  ev(0,0,0,0,0,0,0));
    row(iv(0,0,0,0,0,0,0,0,0,0),     ev(0,0,0,0,0,0,0));
    foreach (tbl[i])
      apply($sformatf("tbl%0d", i), tbl[i].i, 1, tbl[i].o);

    // three-cycle flush, stall suppression, reset mid-flush
    apply("h0", iv(1,0,0,0,0,0,0,0,0,0), 2,
          ev(0,0,0,0,0,0,0));
    apply("h1", iv(0,1,0,0,2,0,1,1,0,0), 2,
          ev(0,0,0,0,0,0,0));
    apply("h2_take", iv(0,1,2,2,5,1,0,0,1,'h40), 2,
          ev(0,0,0,1,1,1,'h40));
    apply("h3_fl", iv(0,1,2,2,4,1,1,0,1,'h55), 2,
          ev(0,0,0,1,0,0,'h40));
    apply("h4_fl", iv(0,1,2,2,4,1,1,0,1,'h55), 2,
          ev(0,0,0,1,0,0,'h40));
    apply("h5_run", iv(0,1,0,0,0,0,0,1,0,0), 2,
          ev(0,0,0,0,0,0,'h40));
    apply("h6_take", iv(0,1,1,2,3,1,0,0,1,'h80), 2,
          ev(0,0,0,1,1,1,'h80));
    apply("h7_rst", iv(1,1,1,2,3,1,0,0,1,'h80), 2,
          ev(0,0,0,0,0,0,0));
    apply("h8_rel", iv(0,1,3,3,3,1,0,0,0,0), 2,
          ev(0,0,0,0,0,0,0));
    apply("h9_acc", iv(0,0,0,0,0,0,0,0,0,0), 2,
          ev(0,0,0,0,0,1,0));

    // random traffic over a small register set
    for (int c = 0; c < 3000; c++) begin
      x.rst  = ($urandom_range(0, 63) == 0);
      x.idv  = ($urandom_range(0, 3) != 0);
      x.rs   = 5'($urandom_range(0, 3));
      x.rt   = 5'($urandom_range(0, 3));
      x.rd   = 5'($urandom_range(0, 3));
      x.rw   = 1'($urandom_range(0, 1));
      x.mr   = ($urandom_range(0, 3) == 0);
      x.br   = ($urandom_range(0, 3) == 0);
      x.zero = 1'($urandom_range(0, 1));
      x.ba   = $urandom;
      apply($sformatf("rnd%0d", c), x, 0, z);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
